// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - operand/result handshake bundle for pipelined_cla_addsub
//
// Purpose: carries the operand channel and the result channel of the
// pipelined CLA adder/subtractor as one bundle.
// Ports (signals):
//   in_valid, in_ready, a[WIDTH], b[WIDTH], cin, sub   operand channel
//   out_valid, out_ready, sum[WIDTH], cout, ovf, zero  result channel
// Modports:
//   master  producer of operands / consumer of results (testbench, upstream)
//   slave   the adder itself
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose: WIDTH-bit add (A+B+cin) or subtract (A-B). Operands are cut into
// BLOCK-bit lookahead groups; each of the L pipeline stages resolves
// GROUPS_PER_STAGE groups and registers its carry-out for the next stage.
// Result appears L edges after acceptance (L = WIDTH/(BLOCK*GROUPS_PER_STAGE)).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low; flushes every in-flight token
//   io     pipelined_cla_addsub_if.slave
//            in_valid/in_ready + a, b, cin, sub      operand channel
//            out_valid/out_ready + sum, cout, ovf, zero  result channel
module pipelined_cla_addsub #(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_cla_addsub_if.slave  io
);
  localparam int S  = BLOCK * GROUPS_PER_STAGE;
  localparam int L  = WIDTH / S;
  localparam int LM = (L > 1) ? L - 1 : 1;

  // Flattened lookahead: every carry c[i+1] is a sum of products of the
  // group's P/G terms and the group carry-in, with no dependence on c[i].
  function automatic logic [BLOCK:0] cla_group(
    input logic [BLOCK-1:0] p,
    input logic [BLOCK-1:0] g,
    input logic             c0
  );
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign advance     = ~io.out_valid | io.out_ready;
  assign io.in_ready = ~rst_n | advance;

  // Subtraction is A + ~B + 1; cin only matters in add mode.
  assign b_eff = io.sub ? ~io.b : io.b;
  assign c_eff = io.sub | io.cin;

  // Per-stage token registers. pa/pb skew the operands still to be added,
  // ps holds the finished low sum bits, pc is the inter-stage carry.
  logic [WIDTH-1:0] pa [LM];
  logic [WIDTH-1:0] pb [LM];
  logic             pc [LM];
  logic [WIDTH-1:0] ps [L];
  logic             pv [L];
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic [S:0]       c;
    logic [WIDTH-1:0] nxt_s;

    if (k == 0) begin : g_src
      assign src_a = io.a;
      assign src_b = b_eff;
      assign src_s = '0;
      assign src_c = c_eff;
      assign src_v = io.in_valid;
    end else begin : g_src
      assign src_a = pa[k-1];
      assign src_b = pb[k-1];
      assign src_s = ps[k-1];
      assign src_c = pc[k-1];
      assign src_v = pv[k-1];
    end

    // Group carry-out chains into the next group within the stage.
    always_comb begin
      c    = '0;
      c[0] = src_c;
      for (int gi = 0; gi < GROUPS_PER_STAGE; gi++) begin
        c[gi*BLOCK +: BLOCK+1] = cla_group(
          src_a[k*S + gi*BLOCK +: BLOCK] ^ src_b[k*S + gi*BLOCK +: BLOCK],
          src_a[k*S + gi*BLOCK +: BLOCK] & src_b[k*S + gi*BLOCK +: BLOCK],
          c[gi*BLOCK]);
      end
      nxt_s          = src_s;
      nxt_s[k*S +: S] = src_a[k*S +: S] ^ src_b[k*S +: S] ^ c[S-1:0];
    end

    // Payload only loads with a valid token, so bubbles never disturb it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pv[k] <= 1'b0;
        ps[k] <= '0;
      end else if (advance) begin
        pv[k] <= src_v;
        if (src_v) ps[k] <= nxt_s;
      end
    end

    if (k < L - 1) begin : g_mid
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pa[k] <= '0;
          pb[k] <= '0;
          pc[k] <= 1'b0;
        end else if (advance && src_v) begin
          pa[k] <= src_a;
          pb[k] <= src_b;
          pc[k] <= c[S];
        end
      end
    end else begin : g_last
      // c[S-1] is the carry into the MSB, c[S] the carry out of it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance && src_v) begin
          cout_q <= c[S];
          ovf_q  <= c[S] ^ c[S-1];
          zero_q <= ~|nxt_s;
        end
      end
    end
  end

  assign io.out_valid = pv[L-1];
  assign io.sum       = ps[L-1];
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
  parameter int WIDTH            = 32;
  parameter int BLOCK            = 4;
  parameter int GROUPS_PER_STAGE = 2;
  localparam int L = WIDTH / (BLOCK * GROUPS_PER_STAGE);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];

  logic acc, emit, ovld, rdy;
  res_t got;

  pipelined_cla_addsub_if #(.WIDTH(WIDTH)) io ();

  pipelined_cla_addsub #(
    .WIDTH(WIDTH),
    .BLOCK(BLOCK),
    .GROUPS_PER_STAGE(GROUPS_PER_STAGE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   full;
    logic             ci;
    res_t             r;
    bp     = sub ? ~b : b;
    ci     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, ci};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bp[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    io.in_valid = v;
    io.a        = a;
    io.b        = b;
    io.cin      = cin;
    io.sub      = sub;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drive_rand();
    drive(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Samples the handshake state for the coming edge, then moves one cycle.
  task automatic tick();
    #1;
    acc  = io.in_valid & io.in_ready & rst_n;
    emit = io.out_valid & io.out_ready;
    ovld = io.out_valid;
    rdy  = io.in_ready;
    got  = {io.sum, io.cout, io.ovf, io.zero};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    io.out_ready = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (io.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready_pre got=%b required=1", io.in_ready);
    end
    tick();
    tick();
    checks++;
    if (ovld !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b required=0", ovld);
    end
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", got);
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b required=1", rdy);
    end
    rst_n        = 1'b1;
    io.out_ready = 1'b1;
    tick();
    checks++;
    if (ovld !== 1'b0 || rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got=%b/%b required=0/1", ovld, rdy);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [8];
    logic [WIDTH-1:0] vb [8];
    logic             vc [8];
    logic             vs [8];
    logic [WIDTH-1:0] maxpos, minneg, t;
    int               n;
    res_t             e;
    maxpos = {1'b0, {(WIDTH-1){1'b1}}};
    minneg = {1'b1, {(WIDTH-1){1'b0}}};
    t      = rnd();
    va[0] = WIDTH'(15); vb[0] = WIDTH'(1); vc[0] = 1'b0; vs[0] = 1'b0;
    va[1] = '1;         vb[1] = WIDTH'(1); vc[1] = 1'b0; vs[1] = 1'b0;
    va[2] = maxpos;     vb[2] = WIDTH'(1); vc[2] = 1'b0; vs[2] = 1'b0;
    va[3] = WIDTH'(5);  vb[3] = WIDTH'(7); vc[3] = 1'b0; vs[3] = 1'b1;
    va[4] = WIDTH'(9);  vb[4] = WIDTH'(9); vc[4] = 1'b0; vs[4] = 1'b1;
    va[5] = WIDTH'(3);  vb[5] = WIDTH'(3); vc[5] = 1'b1; vs[5] = 1'b1;
    va[6] = minneg;     vb[6] = WIDTH'(1); vc[6] = 1'b0; vs[6] = 1'b1;
    va[7] = t;          vb[7] = ~t;        vc[7] = 1'b1; vs[7] = 1'b0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, va[i], vb[i], vc[i], vs[i]);
      tick();
      checks++;
      if (acc !== 1'b1) begin
        failures++;
        $display("FAIL dir_accept[%0d] got=%b required=1", i, acc);
      end else begin
        exp_q.push_back(model(va[i], vb[i], vc[i], vs[i]));
      end
      drive_idle();
      n = 0;
      while (n < 20) begin
        tick();
        if (emit) break;
        n++;
      end
      checks++;
      if (!emit) begin
        failures++;
        $display("FAIL dir_timeout[%0d] got=no_output required=output", i);
      end else if (n != L - 1) begin
        failures++;
        $display("FAIL dir_latency[%0d] got=%0d required=%0d", i, n + 1, L);
      end
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL dir_extra[%0d] got=%h required=none", i, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL dir_result[%0d] got=%h required=%h", i, got, e);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   sent  = 0;
    int   recv  = 0;
    int   cyc   = 0;
    int   first = -1;
    int   last  = -1;
    bit   sending;
    res_t e;
    io.out_ready = 1'b1;
    while (recv < 8 && cyc < 8 + L + 20) begin
      sending = (sent < 8);
      if (sending) drive_rand();
      else drive_idle();
      tick();
      if (sending) begin
        checks++;
        if (acc !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept[%0d] got=%b required=1", sent, acc);
        end else begin
          exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
          sent++;
        end
      end
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra got=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL b2b_result[%0d] got=%h required=%h", recv, got, e);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        recv++;
      end
      cyc++;
    end
    drive_idle();
    checks++;
    if (recv != 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=8", recv);
    end
    checks++;
    if (last - first != 7) begin
      failures++;
      $display("FAIL b2b_gaps got=%0d required=7", last - first);
    end
  endtask

  task automatic test_bubbles();
    int   sent    = 0;
    int   recv    = 0;
    int   cyc     = 0;
    bit   holding = 0;
    res_t e;
    drive_idle();
    while (recv < 16 && cyc < 400) begin
      if (!holding && sent < 16 && $urandom_range(0, 1) == 1) begin
        drive_rand();
        holding = 1;
      end
      io.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) begin
        exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
        sent++;
        holding = 0;
        drive_idle();
      end
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bub_extra got=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL bub_result[%0d] got=%h required=%h", recv, got, e);
          end
        end
        recv++;
      end
      cyc++;
    end
    drive_idle();
    io.out_ready = 1'b1;
    checks++;
    if (recv != 16 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bub_count got=%0d/%0d required=16/0", recv, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    res_t frozen;
    res_t e;
    int   nacc = 0;
    int   nemit = 0;
    int   cyc = 0;
    io.out_ready = 1'b0;
    drive_rand();
    for (int i = 0; i < L + 5; i++) begin
      tick();
      if (acc) begin
        exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
        nacc++;
        drive_rand();
      end else if (!rdy && ovld) begin
        break;
      end
    end
    checks++;
    if (ovld !== 1'b1 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_fill got=%b/%b required=1/0", ovld, rdy);
    end
    checks++;
    if (nacc != L) begin
      failures++;
      $display("FAIL bp_depth got=%0d required=%0d", nacc, L);
    end
    frozen = got;
    repeat (3) begin
      tick();
      checks++;
      if (acc !== 1'b0 || rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready got=%b required=0", rdy);
      end
      checks++;
      if (ovld !== 1'b1 || got !== frozen) begin
        failures++;
        $display("FAIL bp_frozen got=%b:%h required=1:%h", ovld, got, frozen);
      end
    end
    io.out_ready = 1'b1;
    while ((exp_q.size() != 0 || io.in_valid) && cyc < L + 30) begin
      tick();
      if (acc) begin
        exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
        nacc++;
        drive_idle();
      end
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra got=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL bp_result[%0d] got=%h required=%h", nemit, got, e);
          end
        end
        nemit++;
      end
      cyc++;
    end
    drive_idle();
    checks++;
    if (nemit != nacc || exp_q.size() != 0 || nacc != L + 1) begin
      failures++;
      $display("FAIL bp_loss got=%0d/%0d required=%0d", nemit, nacc, L + 1);
    end
  endtask

  task automatic test_reset_midflight();
    res_t e;
    int   nemit = 0;
    int   n;
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
      checks++;
      if (acc !== 1'b1) begin
        failures++;
        $display("FAIL mid_accept[%0d] got=%b required=1", i, acc);
      end else begin
        exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
      end
      if (emit) begin
        checks++;
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL mid_result got=%h required=%h", got, e);
        end
      end
    end
    rst_n        = 1'b0;
    io.out_ready = 1'b0;
    drive_idle();
    tick();
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_in_ready got=%b required=1", rdy);
    end
    rst_n        = 1'b1;
    io.out_ready = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if (ovld !== 1'b0) begin
      failures++;
      $display("FAIL mid_flush got=%b required=0", ovld);
    end
    repeat (L + 3) begin
      tick();
      if (emit) nemit++;
    end
    checks++;
    if (nemit != 0) begin
      failures++;
      $display("FAIL mid_ghost got=%0d required=0", nemit);
    end
    drive(1'b1, WIDTH'(100), WIDTH'(58), 1'b0, 1'b1);
    tick();
    if (acc) exp_q.push_back(model(WIDTH'(100), WIDTH'(58), 1'b0, 1'b1));
    drive_idle();
    n = 0;
    while (n < 20) begin
      tick();
      if (emit) break;
      n++;
    end
    checks++;
    if (!emit || exp_q.size() == 0) begin
      failures++;
      $display("FAIL mid_recover got=no_output required=output");
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL mid_recover got=%h required=%h", got, e);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
